square_gen: RTL
===============

// Module: square_gen
// PURPOSE
//  Programmable square-wave source: turns period/high-time settings into a level output plus rise/fall ticks.
//  Transmit-side counterpart of edge_detect; feeds the frequency meter as an internal calibration source and drives test pins.
//  Config is double-buffered: a new setting takes effect only on a period boundary, so the output never glitches.
// PARAMETERS
//  CNT_W    32   width of period/high counters (cycles of clk)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous, active-low reset
//  en         in   1      run enable (level)
//  load       in   1      1-cycle strobe: capture period_in/high_in into pending regs
//  period_in  in   CNT_W  period P in clk cycles
//  high_in    in   CNT_W  high time H in clk cycles
//  level      out  1      square-wave output (registered)
//  rise_tick  out  1      1-cycle pulse, asserted in the first cycle level==1
//  fall_tick  out  1      1-cycle pulse, asserted in the first cycle level==0 after a high
//  cfg_ack    out  1      1-cycle pulse in the cycle a pending config becomes active
//  cfg_err    out  1      sticky: active P==0; cleared by the next load with P!=0
// BEHAVIOUR
//  Reset: level=0, rise_tick=0, fall_tick=0, cfg_ack=0, cfg_err=0, state=S_IDLE, cnt=0.
//  Active config after reset: P=0, H=0 (invalid) until first load.
//  States: S_IDLE, S_HIGH, S_LOW. All outputs registered; ticks coincide with the level change.
//  S_IDLE: level=0. When en=1 and active P!=0, the next cycle enters S_HIGH (H>0) or S_LOW (H==0).
//  S_HIGH: level=1 for min(H,P) cycles; rise_tick=1 on the entry cycle. Exits to S_LOW after H cycles if H<P.
//  S_LOW: level=0 for P-H cycles; fall_tick=1 on the entry cycle when coming from S_HIGH.
//    On the last low cycle, pending config is applied and the next period starts.
//  Period: exactly P cycles from one rise_tick to the next; high exactly H cycles.
//  Counter: cnt counts 0..P-1 and wraps to 0 at the boundary. Compare H against P at full CNT_W width, unsigned.
//  Degenerate cases:
//    H==0: level stays 0, no ticks; boundaries still occur every P cycles, so config can change.
//    H>=P: level stays 1 after one rise_tick; no fall_tick; boundary every P cycles.
//    P==1 with 0<H: constant high. P==1 with H==0: constant low.
//  load:
//    Captures period_in/high_in into pending and sets pend_valid. A later load overwrites pending; the last load wins.
//    In S_IDLE, pending becomes active the next cycle, with cfg_ack then.
//    While running, pending becomes active at the next period boundary, and cfg_ack pulses in the first cycle of the new period.
//    A load in the same cycle as a boundary goes to the following boundary.
//  en deassert while running: the next cycle, level=0 and state goes to S_IDLE. fall_tick=1 only if level was 1.
//    Pending config is kept; it applies on the IDLE path.
//  en reasserted: the next cycle starts a fresh period with cnt=0.
//  P==0 active: stay in S_IDLE with cfg_err=1.
//  Reset mid-operation: all state is cleared immediately (async), including pending and active config. No tick is emitted on reset.
// STRUCTURE
//  Shared header freq_defs.vh: state encodings S_IDLE/S_HIGH/S_LOW (2-bit) and default CNT_W.
//  Single module; no sub-module. One counter, active/pending register pairs, one FSM.
//  Output logic is computed from next-state, in the same style as edge_detect tick generation.
// TESTING (bench pairs the output with edge_detect in both rising and falling type as a checker)
//  1. Load P=4, H=1, en=1 -> level 1,0,0,0 repeating; rise_tick every 4 cycles; fall_tick 1 cycle after each rise.
//  2. Running P=10, H=5; load P=6, H=2 at cnt=3
//     -> current period completes with 5 high and 5 low cycles; cfg_ack at the next rise; then 2 high and 4 low.
//  3. Degenerate settings:
//     H=0, P=8 -> level 0 forever, no ticks.
//     H=9, P=8 -> one rise_tick, then level 1 forever, no fall_tick.
//     P=0 -> cfg_err=1 and level 0.
//  4. en drop during high (P=10, H=5, cnt=2) -> level 0 and fall_tick next cycle.
//     en=1 later -> rise_tick the cycle after, full 5-cycle high.
//  5. Two loads in consecutive cycles mid-period (P=20, H=10 then P=8, H=3)
//     -> a single cfg_ack at the boundary; P=8, H=3 is active.
//  6. rst_n low mid-high -> level=0 the same cycle (async), no ticks, cfg_err=0.
//     After release, nothing runs until a load.

Source files
------------

// File: rtl/square_gen_pkg.sv
// Shared definitions for the square-wave generator: FSM states and default counter width.
package square_gen_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/square_gen_if.sv
// Control/config inputs and waveform/status outputs of square_gen.
interface square_gen_if
  import square_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             en;
  logic             load;
  logic [CNT_W-1:0] period_in;
  logic [CNT_W-1:0] high_in;
  logic             level;
  logic             rise_tick;
  logic             fall_tick;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (
    output en, load, period_in, high_in,
    input  level, rise_tick, fall_tick, cfg_ack, cfg_err
  );

  modport slave (
    input  en, load, period_in, high_in,
    output level, rise_tick, fall_tick, cfg_ack, cfg_err
  );

endinterface

// File: rtl/square_gen.sv
// Programmable square-wave source with double-buffered period/high-time config.
// Pending config becomes active in IDLE or on a period boundary, so the output never glitches.
module square_gen
  import square_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  square_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_act_p;
  logic [CNT_W-1:0] r_act_h;
  logic [CNT_W-1:0] r_pend_p;
  logic [CNT_W-1:0] r_pend_h;
  logic             r_pend_valid;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             r_ack;
  logic             r_err;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_eff_p;
  logic [CNT_W-1:0] w_eff_h;
  logic             w_last;
  logic             w_apply;
  logic             w_level_nxt;

  // Effective config: the pending one when it is about to be applied, else the active one.
  always_comb begin
    w_eff_p     = r_pend_valid ? r_pend_p : r_act_p;
    w_eff_h     = r_pend_valid ? r_pend_h : r_act_h;
    w_cnt_inc   = r_cnt + CNT_ONE;
    w_last      = (r_cnt == (r_act_p - CNT_ONE));
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_apply     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_apply = r_pend_valid;
        if (bus.en && (w_eff_p != '0)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (w_eff_h != '0) ? S_HIGH : S_LOW;
        end
      end
      S_HIGH, S_LOW: begin
        if (!bus.en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_apply   = r_pend_valid;
          w_cnt_nxt = '0;
          if (w_eff_p == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = (w_eff_h != '0) ? S_HIGH : S_LOW;
          end
        end else begin
          w_cnt_nxt   = w_cnt_inc;
          w_state_nxt = (w_cnt_inc < r_act_h) ? S_HIGH : S_LOW;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_level_nxt = (w_state_nxt == S_HIGH);
  end

  // Ticks derive from the level transition, so H>=P or P==1 naturally produce a single rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_act_p      <= '0;
      r_act_h      <= '0;
      r_pend_p     <= '0;
      r_pend_h     <= '0;
      r_pend_valid <= 1'b0;
      r_level      <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_level_nxt & ~r_level;
      r_fall  <= ~w_level_nxt & r_level;
      r_ack   <= w_apply;

      if (w_apply) begin
        r_act_p <= r_pend_p;
        r_act_h <= r_pend_h;
      end

      // A load coinciding with an apply stays pending for the following boundary.
      if (bus.load) begin
        r_pend_p     <= bus.period_in;
        r_pend_h     <= bus.high_in;
        r_pend_valid <= 1'b1;
      end else if (w_apply) begin
        r_pend_valid <= 1'b0;
      end

      if (w_apply && (r_pend_p == '0)) begin
        r_err <= 1'b1;
      end else if (bus.load && (bus.period_in != '0)) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.level     = r_level;
  assign bus.rise_tick = r_rise;
  assign bus.fall_tick = r_fall;
  assign bus.cfg_ack   = r_ack;
  assign bus.cfg_err   = r_err;

endmodule
